// File: rtl/idex_elastic_reg_if.sv
// idex_elastic_reg_if: ID-side bundle/handshake and EX-side registered bundle for the ID/EX stage
interface idex_elastic_reg_if #(
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int EX_W    = 4,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
);
    logic               id_valid, id_ready, flush, ex_valid, ex_ready;
    logic [WB_W-1:0]    WB, WBreg;
    logic [M_W-1:0]     M, Mreg;
    logic [EX_W-1:0]    EX, EXreg;
    logic [DATA_W-1:0]  DataA, DataB, imm_value, DataAreg, DataBreg, imm_valuereg;
    logic [REG_W-1:0]   RegRs, RegRt, RegRd, RegRsreg, RegRtreg, RegRdreg;
    logic [SHAMT_W-1:0] IDShamt, EXShamt;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output id_valid, flush, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd, IDShamt, ex_ready,
        input  id_ready, ex_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
               RegRsreg, RegRtreg, RegRdreg, EXShamt, stall_cnt
    );
    modport slave (
        input  id_valid, flush, WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd, IDShamt, ex_ready,
        output id_ready, ex_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
               RegRsreg, RegRtreg, RegRdreg, EXShamt, stall_cnt
    );
endinterface

// File: rtl/idex_elastic_reg.sv
// idex_elastic_reg: ID/EX pipeline register with valid/ready handshake, one-entry skid buffer and flush
module idex_elastic_reg #(
    parameter int WB_W    = 2,
    parameter int M_W     = 3,
    parameter int EX_W    = 4,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input logic clock,
    input logic reset_n,
    idex_elastic_reg_if.slave bus
);
    localparam int PW = WB_W + M_W + EX_W + 3 * DATA_W + 3 * REG_W + SHAMT_W;

    logic              main_v, skid_v, main_v_n, skid_v_n, accept, consume, stall, load_main, load_skid;
    logic [PW-1:0]     main_q, skid_q, in_b;
    logic [CNT_W-1:0]  cnt_q;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    logic [EX_W-1:0]   ex_q;

    assign in_b = {bus.WB, bus.M, bus.EX, bus.DataA, bus.DataB, bus.imm_value,
                   bus.RegRs, bus.RegRt, bus.RegRd, bus.IDShamt};

    // state is {main_v, skid_v}: 00 empty, 10 full, 11 skid
    always_comb begin
        accept    = bus.id_valid && !skid_v;
        consume   = main_v && bus.ex_ready;
        stall     = main_v && !bus.ex_ready;
        main_v_n  = !bus.flush && (skid_v || accept || stall);
        skid_v_n  = !bus.flush && (skid_v ? !consume : stall && accept);
        load_main = !bus.flush && (skid_v ? consume : accept && !stall);
        load_skid = !bus.flush && !skid_v && stall && accept;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            if (load_main) main_q <= skid_v ? skid_q : in_b;
            if (load_skid) skid_q <= in_b;
            if (stall && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign {wb_q, m_q, ex_q, bus.DataAreg, bus.DataBreg, bus.imm_valuereg,
            bus.RegRsreg, bus.RegRtreg, bus.RegRdreg, bus.EXShamt} = main_q;

    // control is squashed to a bubble whenever the stage holds nothing
    assign bus.WBreg     = wb_q & {WB_W{main_v}};
    assign bus.Mreg      = m_q & {M_W{main_v}};
    assign bus.EXreg     = ex_q & {EX_W{main_v}};
    assign bus.ex_valid  = main_v;
    assign bus.id_ready  = !skid_v;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: doc/idex_elastic_reg.md
Name: idex_elastic_reg

Overview:
Parametrised next-generation ID/EX pipeline register for the MIPS core. It carries the decode-stage bundle (WB/M/EX control, operand data, immediate, register addresses, shift amount) into EX. It adds a valid/ready handshake with a one-entry skid buffer, so stalls never drop an instruction, plus synchronous flush for branch/exception squash. Control fields are forced to bubble when the stage is empty, and a saturating counter records back-pressure cycles.

Parameters:
WB_W, 2, width of write-back control field
M_W, 3, width of memory control field
EX_W, 4, width of execute control field
DATA_W, 32, width of DataA, DataB, imm_value
REG_W, 5, register address width (Rs, Rt, Rd)
SHAMT_W, 5, shift amount width
CNT_W, 16, stall counter width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID presents a valid bundle
id_ready  out  1  stage can accept a bundle this cycle
flush  in  1  synchronous squash of all held bundles
WB, M, EX  in  WB_W, M_W, EX_W  control fields from ID
DataA, DataB, imm_value  in  DATA_W each  operands and immediate
RegRs, RegRt, RegRd  in  REG_W each  register addresses
IDShamt  in  SHAMT_W  shift amount
ex_valid  out  1  EX-side bundle valid
ex_ready  in  1  EX consumes the bundle this cycle
WBreg, Mreg, EXreg  out  WB_W, M_W, EX_W  control to EX (gated by ex_valid)
DataAreg, DataBreg, imm_valuereg  out  DATA_W each  registered operands
RegRsreg, RegRtreg, RegRdreg  out  REG_W each  registered addresses
EXShamt  out  SHAMT_W  registered shift amount
stall_cnt  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low. Port names are clock and reset_n.
- Reset: main and skid valid bits cleared. All payload registers cleared to 0. stall_cnt = 0. Outputs: ex_valid = 0, all control and data outputs = 0, id_ready = 1.
- Storage: main register drives the outputs. The skid register holds one extra bundle.
- States are encoded by the valid bits:
  - EMPTY: no valid bits set.
  - FULL: main valid only.
  - SKID: main and skid valid.
- id_ready = !skid_valid. It is a registered-state decode with no combinational path from ex_ready.
- ex_valid = main_valid.
- Handshakes: accept when id_valid && id_ready. Consume when ex_valid && ex_ready.
- Transitions (flush = 0):
  - EMPTY: accept -> FULL, main loaded. No accept -> EMPTY.
  - FULL, consume and accept -> FULL, main reloaded with the new bundle.
  - FULL, consume and no accept -> EMPTY.
  - FULL, no consume and accept -> SKID, skid loaded. Main holds.
  - FULL, no consume and no accept -> FULL, hold.
  - SKID (id_ready = 0): consume -> FULL, main <= skid. No consume -> SKID, hold.
- Latency: one cycle from accept to ex_valid when the stage is empty. Throughput is one bundle per cycle with ex_ready held high.
- Ordering is strictly FIFO. No bundle is dropped or duplicated.
- Flush:
  - Any state -> EMPTY on the next edge.
  - Flush overrides a same-cycle accept; the incoming bundle is discarded.
  - A same-cycle consume still counts as consumed by EX.
  - Data payload registers keep their stale values.
- Bubble gating: WBreg, Mreg and EXreg are AND-ed with ex_valid, so they read 0 whenever the stage is empty. This guarantees no spurious register writes or memory access. Data, address and shamt outputs are not gated.
- stall_cnt:
  - Increments on every cycle with ex_valid && !ex_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
  - Flush does not clear it.
- Reset asserted mid-operation: immediate return to reset values regardless of handshake state.

Test Plan:
- Reset then stream: id_valid = 1 with bundles A, B, C on consecutive cycles, ex_ready = 1 -> ex_valid rises 1 cycle after A. Outputs show A, B, C in order. id_ready stays 1. stall_cnt = 0.
- Back-pressure: FULL with A, ex_ready = 0, present B -> SKID. id_ready = 0. Outputs hold A. Raise ex_ready -> A consumed, then B appears. id_ready returns to 1. stall_cnt counts the exact number of stall cycles (e.g. 3 held cycles -> 3).
- Flush in SKID with id_valid = 1 (bundle C) -> next cycle ex_valid = 0, WBreg/Mreg/EXreg = 0, C never appears, id_ready = 1.
- Bubble: WB = 2'b11, M = 3'b101 loaded, then consumed with no new input -> ex_valid = 0 and control outputs read 0. DataAreg retains its last value.
- Saturation: CNT_W = 4, hold ex_ready = 0 for 20 cycles with valid data -> stall_cnt stops at 15.
- Async reset mid-SKID: drop reset_n between clock edges -> ex_valid = 0, id_ready = 1 and all outputs 0 immediately, without waiting for a clock edge.
